// File: rtl/count_pkg.sv
// count_pkg: mode constants, op encoding and priority decode shared by the counter files.
package count_pkg;
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    typedef enum logic [2:0] {OP_HOLD, OP_CLR, OP_LOAD, OP_UP, OP_DOWN} op_e;

    // clr beats load beats a lone inc/dec; inc and dec together cancel
    function automatic op_e decode_op(logic clr, logic load, logic inc, logic dec);
        return clr ? OP_CLR : load ? OP_LOAD : (inc && !dec) ? OP_UP : (dec && !inc) ? OP_DOWN : OP_HOLD;
    endfunction
endpackage

// File: rtl/count_rle_ud_if.sv
// count_rle_ud_if: control and status bundle of the up/down counter.
interface count_rle_ud_if #(parameter int WIDTH = 16);
    logic             clr;
    logic             load;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             ovf;

    modport master (output clr, load, inc, dec, d, step, max, input q, zero, tc, ovf);
    modport slave  (input clr, load, inc, dec, d, step, max, output q, zero, tc, ovf);
endinterface

// File: rtl/count_next.sv
// count_next: combinational next count and terminal-count flag for one op.
module count_next
    import count_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] max_i,
    input  op_e              op_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   lim;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;
    logic             over;
    logic             under;

    // one extra bit keeps max = all-ones wrapping at 2^WIDTH
    always_comb begin
        sum     = {1'b0, q_i} + {1'b0, step_i};
        lim     = {1'b0, max_i} + {{WIDTH{1'b0}}, 1'b1};
        wrap_up = WIDTH'(sum - lim);
        wrap_dn = WIDTH'({1'b0, q_i} + lim - {1'b0, step_i});
        over    = sum > {1'b0, max_i};
        under   = step_i > q_i;
        q_o     = op_i == OP_CLR  ? '0 :
                  op_i == OP_LOAD ? (d_i > max_i ? max_i : d_i) :
                  op_i == OP_UP   ? (!over ? sum[WIDTH-1:0] : mode_i == CNT_SAT ? max_i : wrap_up) :
                  op_i == OP_DOWN ? (!under ? q_i - step_i : mode_i == CNT_SAT ? '0 : wrap_dn) :
                  q_i;
        tc_o    = (op_i == OP_UP && over) || (op_i == OP_DOWN && under);
    end
endmodule

// File: rtl/count_rle_ud.sv
// count_rle_ud: up/down counter with programmable step and limit, wrap or saturate,
// registered terminal-count pulse, sticky overflow and zero flag.
module count_rle_ud
    import count_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    count_rle_ud_if.slave bus
);
    localparam logic MODE = SATURATE ? CNT_SAT : CNT_WRAP;

    op_e              op;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    assign op = decode_op(bus.clr, bus.load, bus.inc, bus.dec);

    count_next #(.WIDTH(WIDTH)) u_next (
        .q_i   (q_q),
        .d_i   (bus.d),
        .step_i(bus.step),
        .max_i (bus.max),
        .op_i  (op),
        .mode_i(MODE),
        .q_o   (q_d),
        .tc_o  (tc_d)
    );

    always_comb ovf_d = (op == OP_CLR || op == OP_LOAD) ? 1'b0 : ovf_q | tc_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q   <= RESET_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.zero = q_q == '0;
    assign bus.tc   = tc_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_count_rle_ud.sv
// tb_count_rle_ud: directed checks of a wrap-mode and a saturate-mode counter sharing stimulus.
module tb_count_rle_ud;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [15:0] d = '0, step = 16'd1, max = 16'hFFFF;
    int          checks = 0;
    int          errors = 0;

    count_rle_ud_if #(.WIDTH(16)) wif ();
    count_rle_ud_if #(.WIDTH(16)) sif ();

    assign wif.clr = clr;  assign wif.load = load; assign wif.inc = inc; assign wif.dec = dec;
    assign wif.d = d;      assign wif.step = step; assign wif.max = max;
    assign sif.clr = clr;  assign sif.load = load; assign sif.inc = inc; assign sif.dec = dec;
    assign sif.d = d;      assign sif.step = step; assign sif.max = max;

    count_rle_ud #(.WIDTH(16), .RESET_VAL(16'd0), .SATURATE(1'b0)) u_wrap (.CLK(CLK), .RST(RST), .bus(wif.slave));
    count_rle_ud #(.WIDTH(16), .RESET_VAL(16'd0), .SATURATE(1'b1)) u_sat  (.CLK(CLK), .RST(RST), .bus(sif.slave));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12 RST = 1'b0;
        #1;
        chk("rst_q", 32'(wif.q), 32'd0);
        chk("rst_zero", 32'(wif.zero), 32'd1);
        chk("rst_tc", 32'(wif.tc), 32'd0);
        chk("rst_ovf", 32'(wif.ovf), 32'd0);
        inc = 1'b1;
        repeat (5) tick();
        chk("count5_q", 32'(wif.q), 32'd5);
        chk("count5_zero", 32'(wif.zero), 32'd0);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_q", 32'(wif.q), 32'd0);
        chk("async_rst_zero", 32'(wif.zero), 32'd1);
        chk("async_rst_tc", 32'(wif.tc), 32'd0);
        chk("async_rst_ovf", 32'(wif.ovf), 32'd0);
        RST = 1'b0;
        inc = 1'b0;
        load = 1'b1; d = 16'h0003;
        tick();
        chk("load3_q", 32'(wif.q), 32'd3);
        load = 1'b0;
        max = 16'd9; step = 16'd3; clr = 1'b1;
        tick();
        chk("clr_q", 32'(wif.q), 32'd0);
        clr = 1'b0; inc = 1'b1;
        tick();
        chk("wrapup_q3", 32'(wif.q), 32'd3);
        chk("wrapup_tc3", 32'(wif.tc), 32'd0);
        tick();
        chk("wrapup_q6", 32'(wif.q), 32'd6);
        tick();
        chk("wrapup_q9", 32'(wif.q), 32'd9);
        chk("wrapup_tc9", 32'(wif.tc), 32'd0);
        chk("wrapup_ovf9", 32'(wif.ovf), 32'd0);
        tick();
        chk("wrapup_q2", 32'(wif.q), 32'd2);
        chk("wrapup_tc2", 32'(wif.tc), 32'd1);
        chk("wrapup_ovf2", 32'(wif.ovf), 32'd1);
        inc = 1'b0;
        tick();
        chk("idle_tc_low", 32'(wif.tc), 32'd0);
        chk("idle_q_hold", 32'(wif.q), 32'd2);
        repeat (9) tick();
        chk("sticky_ovf", 32'(wif.ovf), 32'd1);
        load = 1'b1; d = 16'd0;
        tick();
        chk("load_clears_ovf", 32'(wif.ovf), 32'd0);
        chk("load0_zero", 32'(wif.zero), 32'd1);
        step = 16'd4; d = 16'd8;
        tick();
        chk("sat_load8", 32'(sif.q), 32'd8);
        load = 1'b0; inc = 1'b1;
        tick();
        chk("sat_up_q", 32'(sif.q), 32'd9);
        chk("sat_up_tc", 32'(sif.tc), 32'd1);
        chk("sat_up_ovf", 32'(sif.ovf), 32'd1);
        chk("wrap_8p4_q", 32'(wif.q), 32'd2);
        chk("wrap_8p4_tc", 32'(wif.tc), 32'd1);
        tick();
        chk("sat_again_q", 32'(sif.q), 32'd9);
        chk("sat_again_tc", 32'(sif.tc), 32'd1);
        chk("wrap_2p4_tc", 32'(wif.tc), 32'd0);
        inc = 1'b0; load = 1'b1; d = 16'd2;
        tick();
        load = 1'b0; dec = 1'b1;
        tick();
        chk("sat_dn_q", 32'(sif.q), 32'd0);
        chk("sat_dn_tc", 32'(sif.tc), 32'd1);
        chk("sat_dn_zero", 32'(sif.zero), 32'd1);
        chk("wrap_2m4_q", 32'(wif.q), 32'd8);
        dec = 1'b0; step = 16'd3; load = 1'b1; d = 16'd1;
        tick();
        load = 1'b0; dec = 1'b1;
        tick();
        chk("wrapdn_q", 32'(wif.q), 32'd8);
        chk("wrapdn_tc", 32'(wif.tc), 32'd1);
        dec = 1'b0; max = 16'hFFFF; step = 16'd1; load = 1'b1; d = 16'd0;
        tick();
        load = 1'b0; dec = 1'b1;
        tick();
        chk("wrapdn_full_q", 32'(wif.q), 32'hFFFF);
        chk("wrapdn_full_tc", 32'(wif.tc), 32'd1);
        chk("satdn_full_q", 32'(sif.q), 32'd0);
        dec = 1'b0; load = 1'b1; d = 16'hFFFF;
        tick();
        load = 1'b0; inc = 1'b1;
        tick();
        chk("wrapup_full_q", 32'(wif.q), 32'd0);
        chk("wrapup_full_tc", 32'(wif.tc), 32'd1);
        chk("satup_full_q", 32'(sif.q), 32'hFFFF);
        inc = 1'b0; load = 1'b1; d = 16'd5;
        tick();
        clr = 1'b1; inc = 1'b1; d = 16'd7;
        tick();
        chk("prio_clr_q", 32'(wif.q), 32'd0);
        clr = 1'b0;
        tick();
        chk("prio_load_q", 32'(wif.q), 32'd7);
        load = 1'b0; dec = 1'b1;
        tick();
        chk("incdec_hold_q", 32'(wif.q), 32'd7);
        chk("incdec_hold_tc", 32'(wif.tc), 32'd0);
        inc = 1'b0; dec = 1'b0; max = 16'd9; load = 1'b1; d = 16'd20;
        tick();
        chk("load_clamp_q", 32'(wif.q), 32'd9);
        load = 1'b0; inc = 1'b1; step = 16'd0;
        tick();
        chk("step0_q", 32'(wif.q), 32'd9);
        chk("step0_tc", 32'(wif.tc), 32'd0);
        inc = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/count_rle_ud.md
Name: count_rle_ud

Overview:
- Parametrised successor to the 16-bit load/increment counter: an up/down counter with programmable step, programmable modulo limit and a wrap or saturate mode.
- Adds a registered terminal-count pulse, a sticky overflow flag and a zero flag.
- Used as a PC/index/timer building block in the pipelined CPU. Widths are generic so one block covers 8/16/32-bit uses.

Parameters:
- WIDTH, 16, counter, d, step and max width in bits (>=2).
- RESET_VAL, 0, value of q after reset (must be <= the max applied after reset).
- SATURATE, 0, 0 = wrap modulo (max+1); 1 = clamp at max (up) / 0 (down).

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of d.
- d  in  WIDTH  load value.
- inc  in  1  count up by step.
- dec  in  1  count down by step.
- step  in  WIDTH  increment magnitude; 0 is legal (hold, no tc).
- max  in  WIDTH  upper bound, inclusive; count range 0..max.
- q  out  WIDTH  current count, registered.
- zero  out  1  q == 0, combinational from the q register.
- tc  out  1  one-cycle registered pulse on a wrap or saturate event.
- ovf  out  1  sticky: set by any tc event, cleared by clr/load/RST.

Behaviour:
- Reset (RST=1, asynchronous): q=RESET_VAL, tc=0, ovf=0. zero follows q. The reset takes effect immediately mid-count; the first edge after RST deasserts evaluates normally.
- Priority per edge: clr > load > (inc xor dec) > hold.
- clr: q=0, tc=0, ovf=0.
- load: q=min(d,max), tc=0, ovf=0.
- inc and dec both 1 (with no clr/load): hold, tc=0.
- Up (inc=1, dec=0):
  - Compute s = q+step in WIDTH+1 bits.
  - If s <= max: q=s[WIDTH-1:0], tc=0.
  - Else, wrap mode: q = s-(max+1) and tc=1. Compute in WIDTH+1 bits; max=all-ones gives natural 2^WIDTH wrap.
  - Else, saturate mode: q=max and tc=1.
  - At q==max with step>0 and saturate mode, tc pulses on every further inc edge.
- Down (dec=1, inc=0):
  - If step <= q: q=q-step, tc=0.
  - Else, wrap mode: q = q+(max+1)-step in WIDTH+1 bits, tc=1.
  - Else, saturate mode: q=0 and tc=1.
- Step range:
  - Legal range is step <= max+1.
  - Larger steps give an undefined q value, but tc must still assert. The bench does not check q in that case.
- tc timing: registered in the same edge that updates q. It is high for exactly the one cycle following the wrap/saturate edge, and low otherwise, including hold cycles.
- ovf: set on the same edge tc is set. It stays set until clr, load or RST; tc events do not clear it.
- max changed while q > max (no load): the next inc treats q as past the limit (wrap/saturate rules apply). dec proceeds normally.
- Latency: every control input takes effect at the next rising CLK. No combinational path from inputs to q/tc/ovf.

Decomposition:
- Shared package count_pkg holds the mode constants CNT_WRAP=0 and CNT_SAT=1 and the priority encoding of the op (OP_HOLD, OP_CLR, OP_LOAD, OP_UP, OP_DOWN).
- One sub-module: count_next, purely combinational. It takes q, d, step, max, op and mode, and produces the next q and a tc_next flag.
- The top level holds the registers, the priority decode and ovf.

Test Plan:
- Reset/load (WIDTH=16, max=16'hFFFF):
  - Assert RST mid-count at q=5 -> q=0 immediately (asynchronous), tc=0, ovf=0, zero=1.
  - Load d=16'h0003 -> q=3 next edge.
- Wrap up (max=9, step=3, SATURATE=0):
  - From q=0, apply inc for 4 edges -> q sequence 3,6,9,2.
  - tc=1 only in the cycle after the 9->2 edge; ovf=1 thereafter.
- Saturate (SATURATE=1, max=9, step=4):
  - From q=8, inc -> q=9 with tc=1; inc again -> q=9 with tc=1.
  - From q=2, dec -> q=0 with tc=1; zero=1.
- Wrap down (max=9, step=3):
  - From q=1, dec -> q=8 with tc=1.
  - max=16'hFFFF, step=1, q=0, dec -> q=16'hFFFF with tc=1.
- Priority and simultaneous inputs:
  - clr=load=inc=1 -> q=0.
  - load=inc=1 with d=7 -> q=7.
  - inc=dec=1 -> q holds, tc=0.
  - load d=20 with max=9 -> q=9.
- Sticky flag: after a tc event, 10 idle cycles -> ovf stays 1; then load d=0 -> ovf=0 next cycle.
